if_id_pipe_stage: RTL and testbench
===================================

// Module: if_id_pipe_stage
// PURPOSE
//  Parametrised elastic IF/ID pipeline stage: carries fetched instruction + PC+4 from fetch to decode.
//  Replaces the plain enable-gated IF/ID latch: valid/ready handshake, 2-entry skid buffer
//  (registered in_ready, full throughput), synchronous flush for branch/jump squash.
//  Sits between the fetch unit (upstream) and the decode/hazard logic (downstream).
// PARAMETERS
//  INST_W  32  instruction field width (bits)
//  PC_W    32  PC+4 field width (bits)
//  CNT_W   16  stall-counter width, used only when IFID_STALL_CNT_EN is defined
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-low
//  in_valid    in   1       upstream presents in_inst/in_pc4
//  in_ready    out  1       stage can accept; registered (no comb path from out_ready)
//  in_inst     in   INST_W  fetched instruction
//  in_pc4      in   PC_W    PC+4 of fetched instruction
//  out_valid   out  1       out_inst/out_pc4 valid; registered
//  out_ready   in   1       decode accepts this cycle
//  out_inst    out  INST_W  instruction to decode
//  out_pc4     out  PC_W    PC+4 to decode
//  flush       in   1       synchronous squash of all held entries
//  stall_cnt   out  CNT_W   [IFID_STALL_CNT_EN only] cycles with in_ready=0 due to FULL
// BEHAVIOUR
//  - Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Storage: main reg (drives outputs) + skid reg. States EMPTY / ONE / FULL.
//    out_valid = (state != EMPTY); in_ready = (state != FULL). Both pure flop outputs.
//  - EMPTY: in_fire -> ONE, main <= in.  else stay.
//  - ONE:   in_fire & out_fire -> ONE, main <= in;  in_fire & !out_fire -> FULL, skid <= in;
//           !in_fire & out_fire -> EMPTY;  else hold.
//  - FULL:  in_ready=0; out_fire -> ONE, main <= skid;  else hold.
//  - Ordering preserved: skid entry always younger than main entry.
//  - Latency 1 cycle in->out when EMPTY; sustained throughput 1 transfer/cycle.
//  - flush=1: next state EMPTY regardless of fires; any in_fire that cycle is discarded;
//    an out_fire in the flush cycle counts as delivered (out_valid not gated by flush).
//    Data regs need not clear on flush; out_valid=0 masks them.
//  - out_inst/out_pc4 hold value when no main update (stable while out_valid & !out_ready).
//  - Reset (any time, incl. mid-transfer): state EMPTY, out_valid=0, in_ready=1,
//    out_inst=0, out_pc4=0, skid regs=0, stall_cnt=0. Contents lost, no partial transfer.
//  - Illegal state encoding -> EMPTY next cycle.
// CONFIGURATION
//  IFID_STALL_CNT_EN defined: stall_cnt port present; +1 each cycle state==FULL & in_valid,
//    saturates at 2^CNT_W-1; cleared only by reset (not by flush).
//  Undefined: port and counter logic absent; data-path behaviour identical.
// TESTING
//  1. Reset: rst=0 mid-stream -> out_valid=0, in_ready=1, out_inst=0, out_pc4=0 same cycle.
//  2. Streaming: out_ready=1, 8 back-to-back in_valid (inst=0x1000+i) -> out in order,
//     1 cycle latency, in_ready never drops.
//  3. Back-pressure: out_ready=0, push 0xA,0xB -> FULL, in_ready=0, 0xC held upstream;
//     raise out_ready -> 0xA,0xB,0xC out in order, no loss/dup.
//  4. Flush in FULL with in_valid=1 (0xD) -> next cycle out_valid=0, in_ready=1, 0xD dropped.
//  5. Flush with out_ready=1 in ONE (0xE held) -> 0xE counted delivered, stage EMPTY after.
//  6. IFID_STALL_CNT_EN, CNT_W=4: hold FULL with in_valid=1 for 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/if_id_pipe_stage.sv
// rtl/if_id_pipe_stage.sv - elastic IF/ID stage with 2-entry skid buffer and flush
// Optional stall counter on output port stall_cnt when IFID_STALL_CNT_EN is defined.
module if_id_pipe_stage #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc4,
  input  logic              flush
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d;
  logic [PC_W-1:0]     main_pc4_q, main_pc4_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]     skid_pc4_q, skid_pc4_d;
  logic                in_fire;
  logic                out_fire;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc4_d  = main_pc4_q;
    skid_inst_d = skid_inst_q;
    skid_pc4_d  = skid_pc4_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d     = ST_ONE;
          main_inst_d = in_inst;
          main_pc4_d  = in_pc4;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_inst_d = in_inst;
          main_pc4_d  = in_pc4;
        end else if (in_fire) begin
          state_d     = ST_FULL;
          skid_inst_d = in_inst;
          skid_pc4_d  = in_pc4;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Skid entry is always the younger one, so it moves up behind main.
        if (out_fire) begin
          state_d     = ST_ONE;
          main_inst_d = skid_inst_q;
          main_pc4_d  = skid_pc4_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d     = ST_EMPTY;
      main_inst_d = main_inst_q;
      main_pc4_d  = main_pc4_q;
      skid_inst_d = skid_inst_q;
      skid_pc4_d  = skid_pc4_q;
    end
    // Handshake flags are flopped copies of the next-state decode.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_inst_q <= '0;
      main_pc4_q  <= '0;
      skid_inst_q <= '0;
      skid_pc4_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_inst_q <= main_inst_d;
      main_pc4_q  <= main_pc4_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = main_inst_q;
  assign out_pc4   = main_pc4_q;

`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts upstream wait cycles caused by a full buffer; flush leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_FULL) && in_valid && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb/tb_if_id_pipe_stage.sv - scoreboard bench for if_id_pipe_stage
module tb_if_id_pipe_stage;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INST_W-1:0] in_inst = '0;
  logic [PC_W-1:0]   in_pc4 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc4;
  logic              flush = 1'b0;
`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  if_id_pipe_stage #(
    .INST_W(INST_W),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc4   (in_pc4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc4  (out_pc4),
    .flush    (flush)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc4;
  } item_t;

  // Reference: the stage is a 2-deep FIFO whose occupancy is the queue length.
  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    delivered = 0;
  int    stall_model = 0;
  bit    chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() != 0});
      check("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() < 2});
`ifdef IFID_STALL_CNT_EN
      check("stall_cnt", {60'b0, stall_cnt}, 64'(stall_model));
      if (exp_q.size() == 2 && in_valid && stall_model < CNT_MAX) stall_model++;
`endif
      if (exp_q.size() != 0) begin
        if (out_valid) check("out_data", {out_inst, out_pc4}, {exp_q[0].inst, exp_q[0].pc4});
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
  end

  // One upstream cycle: drive, then record what the stage accepted.
  task automatic cycle(input logic v, input logic [INST_W-1:0] inst, input logic [PC_W-1:0] pc4,
                       input logic ordy, input logic fl, output bit fired);
    item_t it;
    in_valid  = v;
    in_inst   = inst;
    in_pc4    = pc4;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    fired = v && in_ready;
    it.inst = inst;
    it.pc4  = pc4;
    if (fl) exp_q.delete();
    else if (fired) exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit f;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, f);
  endtask

  task automatic apply_reset();
    chk_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_inst", {32'b0, out_inst}, 64'd0);
    check("rst_out_pc4", {32'b0, out_pc4}, 64'd0);
`ifdef IFID_STALL_CNT_EN
    check("rst_stall_cnt", {60'b0, stall_cnt}, 64'd0);
`endif
    exp_q.delete();
    stall_model = 0;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int tries;
    int d0;

    @(posedge clk);
    #1;
    apply_reset();

    // Streaming: 8 back-to-back, in_ready must stay high.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, INST_W'(32'h1000 + i), $urandom, 1'b1, 1'b0, f);
      check("stream_accept", {63'b0, f}, 64'd1);
    end
    idle(3);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: A, B fill the buffer; C waits upstream.
    cycle(1'b1, 32'hA, $urandom, 1'b0, 1'b0, f);
    cycle(1'b1, 32'hB, $urandom, 1'b0, 1'b0, f);
    cycle(1'b1, 32'hC, 32'h0C0C, 1'b0, 1'b0, f);
    check("bp_c_held", {63'b0, f}, 64'd0);
    tries = 0;
    do begin
      cycle(1'b1, 32'hC, 32'h0C0C, 1'b1, 1'b0, f);
      tries++;
    end while (!f && tries < 5);
    check("bp_c_accepted", {63'b0, f}, 64'd1);
    idle(4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush while FULL with 0xD offered.
    cycle(1'b1, 32'h11, $urandom, 1'b0, 1'b0, f);
    cycle(1'b1, 32'h12, $urandom, 1'b0, 1'b0, f);
    cycle(1'b1, 32'hD, $urandom, 1'b0, 1'b1, f);
    check("flush_full_valid", {63'b0, out_valid}, 64'd0);
    check("flush_full_ready", {63'b0, in_ready}, 64'd1);
    idle(3);

    // Flush in ONE with out_ready=1: 0xE is delivered, then empty.
    cycle(1'b1, 32'hE, $urandom, 1'b0, 1'b0, f);
    d0 = delivered;
    cycle(1'b0, '0, '0, 1'b1, 1'b1, f);
    check("flush_one_delivered", 64'(delivered - d0), 64'd1);
    check("flush_one_empty", {63'b0, out_valid}, 64'd0);
    idle(2);

    // Randomized traffic including occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0,
            ($urandom % 32) == 0, f);
    end
    idle(3);

    // Asynchronous reset with the buffer full.
    cycle(1'b1, 32'h21, $urandom, 1'b0, 1'b0, f);
    cycle(1'b1, 32'h22, $urandom, 1'b0, 1'b0, f);
    apply_reset();
    idle(2);

`ifdef IFID_STALL_CNT_EN
    cycle(1'b1, 32'h31, $urandom, 1'b0, 1'b0, f);
    cycle(1'b1, 32'h32, $urandom, 1'b0, 1'b0, f);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h33, $urandom, 1'b0, 1'b0, f);
    check("stall_sat", {60'b0, stall_cnt}, 64'(CNT_MAX));
    cycle(1'b0, '0, '0, 1'b0, 1'b1, f);
    idle(2);
    check("stall_after_flush", {60'b0, stall_cnt}, 64'(CNT_MAX));
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
